axi_frame_rd_responder: RTL and testbench

AXI_FRAME_RD_RESPONDER -- requirements
Module: axi_frame_rd_responder

---
 rtl/axi_frame_rd_responder_if.sv | 33 +++
 rtl/axi_frame_rd_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_frame_rd_responder.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_frame_rd_responder_if.sv
// AXI-style read request (AR) and read data (R) channels of the frame read responder.
// The responder side connects through the slave modport and the requester side through the master modport.
interface axi_frame_rd_responder_if;
   logic [3:0]   mem_arid;
   logic [26:0]  mem_araddr;
   logic [7:0]   mem_arlen;
   logic [2:0]   mem_arsize;
   logic [1:0]   mem_arburst;
   logic         mem_arlock;
   logic         mem_arvalid;
   logic         mem_arready;

   logic [3:0]   mem_rid;
   logic [127:0] mem_rdata;
   logic [1:0]   mem_rresp;
   logic         mem_rlast;
   logic         mem_rvalid;
   logic         mem_rready;

   modport master (
      output mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arlock, mem_arvalid,
      input  mem_arready,
      input  mem_rid, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
      output mem_rready
   );

   modport slave (
      input  mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arlock, mem_arvalid,
      output mem_arready,
      output mem_rid, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
      input  mem_rready
   );
endinterface

// File: rtl/axi_frame_rd_responder.sv
// Read-only AXI burst responder in front of a DEPTH_WORDS x 128-bit frame store.
// Requests are queued two deep; beats go through a registered RAM read and a two-entry output skid buffer.
module axi_frame_rd_responder #(
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic                           mem_clk,
   input  logic                           mem_reset,
   axi_frame_rd_responder_if.slave        axi,
   input  logic                           wr_en,
   input  logic [15:0]                    wr_addr,
   input  logic [127:0]                   wr_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef struct packed {
      logic [3:0]  id;
      logic [22:0] base;
      logic [7:0]  len;
      logic        fixed;
      logic        slverr;
   } req_t;

   typedef struct packed {
      logic [3:0]   id;
      logic [1:0]   resp;
      logic         last;
      logic [127:0] data;
   } beat_t;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   logic [127:0] mem [DEPTH_WORDS];
   logic [127:0] rdData_q;

   req_t        fifoHead_q, fifoHead_d;
   req_t        fifoTail_q, fifoTail_d;
   logic [1:0]  fifoCount_q, fifoCount_d;
   logic        arready_q, arready_d;

   state_t      state_q;
   logic [7:0]  beat_q;

   logic        pipeValid_q, pipeValid_d;
   logic [3:0]  pipeId_q, pipeId_d;
   logic [1:0]  pipeResp_q, pipeResp_d;
   logic        pipeLast_q, pipeLast_d;

   beat_t       skid0_q, skid0_d;
   beat_t       skid1_q, skid1_d;
   logic [1:0]  skidCount_q, skidCount_d;

   req_t        newReq;
   logic        arHandshake;
   logic [7:0]  curBeat;
   logic [22:0] beatWord;
   logic        outOfRange;
   logic [1:0]  beatResp;
   logic        lastBeat;
   logic        rValid;
   logic        rPop;
   logic [2:0]  occupancy;
   logic        issue;
   logic        fifoPop;
   logic        wrInRange;
   beat_t       pipeBeat;
   beat_t       rOut;
   logic        unusedBits;

   assign unusedBits = ^{axi.mem_arlock, axi.mem_araddr[3:0]};

   // Request decode: illegal size/burst is flagged once at acceptance and answered with SLVERR beats.
   always_comb begin
      newReq        = '0;
      newReq.id     = axi.mem_arid;
      newReq.base   = axi.mem_araddr[26:4];
      newReq.len    = axi.mem_arlen;
      newReq.fixed  = (axi.mem_arburst == 2'b00);
      newReq.slverr = (axi.mem_arsize != 3'b100) || axi.mem_arburst[1];
   end

   assign arHandshake = axi.mem_arvalid && arready_q;

   // Beat generation works straight off the FIFO head so a new burst starts without a bubble.
   assign curBeat    = (state_q == BURST) ? beat_q : 8'd0;
   assign beatWord   = fifoHead_q.fixed ? fifoHead_q.base : fifoHead_q.base + {15'd0, curBeat};
   assign outOfRange = ({9'd0, beatWord} >= DEPTH_WORDS);
   assign beatResp   = fifoHead_q.slverr ? 2'b10 : (outOfRange ? 2'b11 : 2'b00);
   assign lastBeat   = (curBeat == fifoHead_q.len);

   assign rValid    = (skidCount_q != 2'd0) || pipeValid_q;
   assign rPop      = rValid && axi.mem_rready;
   assign occupancy = {1'b0, skidCount_q} + {2'b00, pipeValid_q} - {2'b00, rPop};
   assign issue     = (fifoCount_q != 2'd0) && (occupancy < 3'd2);
   assign fifoPop   = issue && lastBeat;

   assign wrInRange = wr_en && ({16'd0, wr_addr} < DEPTH_WORDS);

   // Storage has no reset so its contents survive a mid-burst reset; reads are read-first.
   always_ff @(posedge mem_clk) begin
      if (wrInRange) begin
         mem[wr_addr[AW-1:0]] <= wr_data;
      end
      if (issue) begin
         rdData_q <= mem[beatWord[AW-1:0]];
      end
   end

   // Two-entry request FIFO; arready is registered from the next occupancy.
   always_comb begin
      fifoHead_d  = fifoHead_q;
      fifoTail_d  = fifoTail_q;
      fifoCount_d = fifoCount_q;
      unique case ({arHandshake, fifoPop})
         2'b10: begin
            if (fifoCount_q == 2'd0) begin
               fifoHead_d = newReq;
            end else begin
               fifoTail_d = newReq;
            end
            fifoCount_d = fifoCount_q + 2'd1;
         end
         2'b01: begin
            fifoHead_d  = fifoTail_q;
            fifoCount_d = fifoCount_q - 2'd1;
         end
         2'b11: begin
            if (fifoCount_q == 2'd1) begin
               fifoHead_d = newReq;
            end else begin
               fifoHead_d = fifoTail_q;
               fifoTail_d = newReq;
            end
         end
         default: begin
         end
      endcase
      arready_d = (fifoCount_d != 2'd2);
   end

   // Burst engine: IDLE issues beat 0 of the head, BURST walks the remaining beats.
   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         state_q <= IDLE;
         beat_q  <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue && !lastBeat) begin
                  state_q <= BURST;
                  beat_q  <= 8'd1;
               end
            end
            BURST: begin
               if (issue) begin
                  if (lastBeat) begin
                     state_q <= IDLE;
                     beat_q  <= 8'd0;
                  end else begin
                     beat_q  <= beat_q + 8'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               beat_q  <= 8'd0;
            end
         endcase
      end
   end

   // Sideband travels alongside the RAM read so it lines up with rdData_q one cycle later.
   always_comb begin
      pipeValid_d = issue;
      pipeId_d    = fifoHead_q.id;
      pipeResp_d  = beatResp;
      pipeLast_d  = lastBeat;
   end

   always_comb begin
      pipeBeat      = '0;
      pipeBeat.id   = pipeId_q;
      pipeBeat.resp = pipeResp_q;
      pipeBeat.last = pipeLast_q;
      pipeBeat.data = (pipeResp_q == 2'b00) ? rdData_q : 128'd0;
   end

   // Skid buffer: a beat leaving the RAM goes straight out if nothing is queued ahead of it, else it is parked.
   always_comb begin
      skid0_d     = skid0_q;
      skid1_d     = skid1_q;
      skidCount_d = skidCount_q;
      if (rPop && (skidCount_q != 2'd0)) begin
         skid0_d     = skid1_q;
         skidCount_d = skidCount_q - 2'd1;
      end
      if (pipeValid_q && !(rPop && (skidCount_q == 2'd0))) begin
         if (skidCount_d == 2'd0) begin
            skid0_d = pipeBeat;
         end else begin
            skid1_d = pipeBeat;
         end
         skidCount_d = skidCount_d + 2'd1;
      end
   end

   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         fifoHead_q  <= '0;
         fifoTail_q  <= '0;
         fifoCount_q <= 2'd0;
         arready_q   <= 1'b0;
         pipeValid_q <= 1'b0;
         pipeId_q    <= 4'd0;
         pipeResp_q  <= 2'd0;
         pipeLast_q  <= 1'b0;
         skid0_q     <= '0;
         skid1_q     <= '0;
         skidCount_q <= 2'd0;
      end else begin
         fifoHead_q  <= fifoHead_d;
         fifoTail_q  <= fifoTail_d;
         fifoCount_q <= fifoCount_d;
         arready_q   <= arready_d;
         pipeValid_q <= pipeValid_d;
         pipeId_q    <= pipeId_d;
         pipeResp_q  <= pipeResp_d;
         pipeLast_q  <= pipeLast_d;
         skid0_q     <= skid0_d;
         skid1_q     <= skid1_d;
         skidCount_q <= skidCount_d;
      end
   end

   always_comb begin
      if (skidCount_q != 2'd0) begin
         rOut = skid0_q;
      end else if (pipeValid_q) begin
         rOut = pipeBeat;
      end else begin
         rOut = '0;
      end
   end

   assign axi.mem_arready = arready_q;
   assign axi.mem_rvalid  = rValid;
   assign axi.mem_rid     = rOut.id;
   assign axi.mem_rresp   = rOut.resp;
   assign axi.mem_rlast   = rOut.last;
   assign axi.mem_rdata   = rOut.data;

endmodule

// File: tb/tb_axi_frame_rd_responder.sv
// Scoreboard bench for axi_frame_rd_responder with a 16-word store: expected beats are queued at request time
// and a negedge monitor pops and compares every accepted R beat, also watching hold behaviour while stalled.
module tb_axi_frame_rd_responder;

   typedef struct {
      logic [3:0]   id;
      logic [1:0]   resp;
      logic         last;
      logic [127:0] data;
   } expBeat_t;

   logic         clk;
   logic         rst;
   logic         wrEn;
   logic [15:0]  wrAddr;
   logic [127:0] wrData;
   logic         toggleMode;

   axi_frame_rd_responder_if bus ();

   axi_frame_rd_responder #(
      .DEPTH_WORDS (16)
   ) dut (
      .mem_clk   (clk),
      .mem_reset (rst),
      .axi       (bus),
      .wr_en     (wrEn),
      .wr_addr   (wrAddr),
      .wr_data   (wrData)
   );

   expBeat_t     expQ[$];
   expBeat_t     monExp;
   logic [127:0] model [16];
   int           checks;
   int           errors;
   int           beatsSeen;
   logic         stallSeen;
   logic [135:0] heldBeat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (toggleMode) begin
         #1 bus.mem_rready = ~bus.mem_rready;
      end
   end

   task automatic checkOutput(input string name, input logic [135:0] actual, input logic [135:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [135:0] packBeat(input logic [3:0] id, input logic [1:0] resp, input logic last,
                                             input logic [127:0] data);
      return {1'b0, id, resp, last, data};
   endfunction

   // Monitor: compares each accepted beat and checks that a stalled beat does not change.
   always @(negedge clk) begin
      if (rst) begin
         stallSeen = 1'b0;
      end else begin
         if (bus.mem_rvalid) begin
            if (stallSeen) begin
               checkOutput("hold", packBeat(bus.mem_rid, bus.mem_rresp, bus.mem_rlast, bus.mem_rdata), heldBeat);
            end
            if (bus.mem_rready) begin
               stallSeen = 1'b0;
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected beat: got id %0h resp %0h data %0h, required none",
                           bus.mem_rid, bus.mem_rresp, bus.mem_rdata);
               end else begin
                  monExp = expQ.pop_front();
                  checkOutput($sformatf("beat%0d", beatsSeen),
                              packBeat(bus.mem_rid, bus.mem_rresp, bus.mem_rlast, bus.mem_rdata),
                              packBeat(monExp.id, monExp.resp, monExp.last, monExp.data));
               end
               beatsSeen++;
            end else begin
               stallSeen = 1'b1;
               heldBeat  = packBeat(bus.mem_rid, bus.mem_rresp, bus.mem_rlast, bus.mem_rdata);
            end
         end else if (stallSeen) begin
            stallSeen = 1'b0;
            checkOutput("rvalid dropped while stalled", 136'd0, 136'd1);
         end
      end
   end

   task automatic pushBeat(input logic [3:0] id, input logic [1:0] resp, input logic last, input logic [127:0] data);
      expBeat_t e;
      e.id   = id;
      e.resp = resp;
      e.last = last;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic pushExpected(input logic [3:0] id, input logic [26:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
      logic [22:0] w;
      logic [1:0]  resp;
      for (int n = 0; n <= int'(len); n++) begin
         w = (burst == 2'b00) ? addr[26:4] : addr[26:4] + 23'(n);
         if (size != 3'b100 || burst[1]) begin
            resp = 2'b10;
         end else if (w >= 23'd16) begin
            resp = 2'b11;
         end else begin
            resp = 2'b00;
         end
         pushBeat(id, resp, n == int'(len), (resp == 2'b00) ? model[w[3:0]] : 128'd0);
      end
   endtask

   // Called just after a posedge; returns just after the edge that completed the AR handshake.
   task automatic applyStimulus(input logic [3:0] id, input logic [26:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input bit doPush);
      bit ok;
      bus.mem_arid    = id;
      bus.mem_araddr  = addr;
      bus.mem_arlen   = len;
      bus.mem_arsize  = size;
      bus.mem_arburst = burst;
      bus.mem_arlock  = 1'b0;
      bus.mem_arvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         ok = bus.mem_arready;
         @(posedge clk);
         #1;
      end
      bus.mem_arvalid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL ar handshake timeout: got arready 0, required 1");
      end else if (doPush) begin
         pushExpected(id, addr, len, size, burst);
      end
   endtask

   task automatic writeWord(input logic [15:0] addr, input logic [127:0] data);
      wrEn   = 1'b1;
      wrAddr = addr;
      wrData = data;
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      if (addr < 16'd16) begin
         model[addr[3:0]] = data;
      end
   endtask

   task automatic waitIdle(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         done = (expQ.size() == 0) && !bus.mem_rvalid;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain timeout: got %0d beats outstanding, required 0", expQ.size());
         expQ.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic countValid(input string name, input int cycles);
      int hi;
      hi = 0;
      for (int c = 0; c < cycles; c++) begin
         if (c > 0) begin
            @(negedge clk);
         end
         if (bus.mem_rvalid) begin
            hi++;
         end
      end
      checkOutput(name, 136'(hi), 136'(cycles));
   endtask

   initial begin
      int target;
      checks          = 0;
      errors          = 0;
      beatsSeen       = 0;
      stallSeen       = 1'b0;
      toggleMode      = 1'b0;
      rst             = 1'b1;
      wrEn            = 1'b0;
      wrAddr          = 16'd0;
      wrData          = 128'd0;
      bus.mem_arvalid = 1'b0;
      bus.mem_arid    = 4'd0;
      bus.mem_araddr  = 27'd0;
      bus.mem_arlen   = 8'd0;
      bus.mem_arsize  = 3'b100;
      bus.mem_arburst = 2'b01;
      bus.mem_arlock  = 1'b0;
      bus.mem_rready  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         model[i] = 128'd0;
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset outputs", {bus.mem_arready, bus.mem_rvalid, bus.mem_rlast, bus.mem_rid, bus.mem_rresp,
                                    bus.mem_rdata}, 136'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("arready before first edge", 136'(bus.mem_arready), 136'd0);
      @(posedge clk);
      #1;
      checkOutput("arready after first edge", 136'(bus.mem_arready), 136'd1);

      for (int i = 0; i < 16; i++) begin
         writeWord(16'(i), 128'(i));
      end
      writeWord(16'd21, 128'hDEAD_BEEF);

      $display("[TB] INCR burst id 3, len 7, rready high");
      applyStimulus(4'd3, 27'h0, 8'd7, 3'b100, 2'b01, 1'b1);
      @(negedge clk);
      checkOutput("latency T+1 rvalid", 136'(bus.mem_rvalid), 136'd0);
      @(negedge clk);
      checkOutput("latency T+2 rvalid", 136'(bus.mem_rvalid), 136'd1);
      @(negedge clk);
      countValid("contiguous beats 1-7", 7);
      waitIdle(50);

      $display("[TB] INCR burst id 3, len 7, rready toggling");
      toggleMode = 1'b1;
      applyStimulus(4'd3, 27'h0, 8'd7, 3'b100, 2'b01, 1'b1);
      waitIdle(100);
      toggleMode = 1'b0;
      @(posedge clk);
      #2 bus.mem_rready = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] back-to-back requests len 0, 3, 1");
      applyStimulus(4'd1, 27'h20, 8'd0, 3'b100, 2'b01, 1'b1);
      applyStimulus(4'd2, 27'h40, 8'd3, 3'b100, 2'b01, 1'b1);
      applyStimulus(4'd4, 27'h80, 8'd1, 3'b100, 2'b01, 1'b1);
      @(negedge clk);
      checkOutput("arready low when full", 136'(bus.mem_arready), 136'd0);
      countValid("back-to-back contiguity", 6);
      waitIdle(50);

      $display("[TB] decode and slave errors");
      applyStimulus(4'd6, 27'hE0, 8'd3, 3'b100, 2'b01, 1'b1);
      applyStimulus(4'd7, 27'h10, 8'd1, 3'b010, 2'b01, 1'b1);
      applyStimulus(4'd8, 27'h10, 8'd0, 3'b100, 2'b10, 1'b1);
      waitIdle(50);

      $display("[TB] FIXED burst with concurrent rewrite");
      applyStimulus(4'd9, 27'h50, 8'd3, 3'b100, 2'b00, 1'b0);
      pushBeat(4'd9, 2'b00, 1'b0, 128'd5);
      pushBeat(4'd9, 2'b00, 1'b0, 128'd5);
      pushBeat(4'd9, 2'b00, 1'b0, 128'hA5A5_0000_1234);
      pushBeat(4'd9, 2'b00, 1'b1, 128'hA5A5_0000_1234);
      @(posedge clk);
      #1;
      writeWord(16'd5, 128'hA5A5_0000_1234);
      waitIdle(50);

      $display("[TB] reset mid-burst");
      target = beatsSeen + 2;
      applyStimulus(4'd10, 27'h0, 8'd7, 3'b100, 2'b01, 1'b1);
      for (int c = 0; c < 40 && beatsSeen < target; c++) begin
         @(posedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("rvalid cleared by reset", 136'(bus.mem_rvalid), 136'd0);
      checkOutput("arready cleared by reset", 136'(bus.mem_arready), 136'd0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("no beats after reset", {bus.mem_rvalid, bus.mem_rdata}, 136'd0);
      applyStimulus(4'd11, 27'h0, 8'd3, 3'b100, 2'b01, 1'b1);
      waitIdle(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got no completion, required $finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
